// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift-counter sequencer: FSM state encoding,
// shift-mode constants and the feedback-bit helper used by the shift core.
package shift_seq_pkg;

  // Sequencer states (IDLE -> LOAD -> RUN -> DONE -> IDLE)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Shift modes
  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  // Bit fed into the LSB on a left shift: ring recirculates the MSB,
  // Johnson feeds back its complement (twisted ring).
  function automatic logic feed_bit(input logic mode, input logic msb);
    logic fb;
    case (mode)
      MODE_RING:    fb = msb;
      MODE_JOHNSON: fb = ~msb;
      default:      fb = msb;
    endcase
    return fb;
  endfunction

endpackage

// File: rtl/shift_core.sv
// Embedded shift register: parallel load has priority over shifting, and
// with en low the register holds. Shifts left with LSB feedback chosen by mode.
module shift_core
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // Shift register: reset, then load, then one left shift, else hold
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= {WIDTH{1'b0}};
    end else if (ld) begin
      q_r <= d;
    end else if (en) begin
      q_r <= {q_r[WIDTH-2:0], feed_bit(mode, q_r[WIDTH-1])};
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for ring/Johnson shift counters. A start in IDLE latches
// mode/seed/steps, the core is loaded with the seed for one cycle, then
// shifted 'steps' times (pausable with hold), and a one-cycle done pulse
// closes the run. All outputs come straight from registers.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNTW-1:0]  steps,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [CNTW-1:0]  step_cnt
);

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic             mode_r;
  logic [WIDTH-1:0] seed_r;
  logic [CNTW-1:0]  steps_r;
  logic [CNTW-1:0]  step_cnt_r;
  logic [CNTW-1:0]  cnt_inc_s;
  logic             busy_r;
  logic             done_r;
  logic             ld_s;
  logic             en_s;

  assign cnt_inc_s = step_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
  assign ld_s      = (state_r == ST_LOAD);
  assign en_s      = (state_r == ST_RUN) && !hold;

  // Next-state logic; the run ends on the shift that reaches the target count
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (steps_r == {CNTW{1'b0}}) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!hold && (cnt_inc_s == steps_r)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered status outputs, derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Run configuration, captured only when a start is accepted in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r  <= MODE_RING;
      seed_r  <= {WIDTH{1'b0}};
      steps_r <= {CNTW{1'b0}};
    end else if ((state_r == ST_IDLE) && start) begin
      mode_r  <= mode;
      seed_r  <= seed;
      steps_r <= steps;
    end else begin
      mode_r  <= mode_r;
      seed_r  <= seed_r;
      steps_r <= steps_r;
    end
  end

  // Step counter: cleared on load, counts each performed shift, else holds
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt_r <= {CNTW{1'b0}};
    end else if (ld_s) begin
      step_cnt_r <= {CNTW{1'b0}};
    end else if (en_s) begin
      step_cnt_r <= cnt_inc_s;
    end else begin
      step_cnt_r <= step_cnt_r;
    end
  end

  shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld_s),
    .en   (en_s),
    .mode (mode_r),
    .d    (seed_r),
    .q    (q)
  );

  assign busy     = busy_r;
  assign done     = done_r;
  assign step_cnt = step_cnt_r;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl. Each directed run pushes the expected
// per-busy-cycle outputs and the hand-computed final result into queues; an
// independent monitor on the falling edge pops and compares them.
module tb_shift_seq_ctrl;

  localparam int W = 8;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         mode;
  logic [W-1:0] seed;
  logic [C-1:0] steps;
  logic         hold;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [C-1:0] step_cnt;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(W), .CNTW(C)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .seed     (seed),
    .steps    (steps),
    .hold     (hold),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .step_cnt (step_cnt)
  );

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] cnt;
    logic       done;
  } cyc_t;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] cnt;
  } fin_t;

  cyc_t cyc_q[$];
  fin_t fin_q[$];
  cyc_t mon_e;
  fin_t mon_f;

  int total = 0;
  int bad   = 0;

  logic [7:0] idle_q   = 8'd0;
  logic [7:0] idle_cnt = 8'd0;
  logic [7:0] m_q      = 8'd0;
  logic [7:0] m_cnt    = 8'd0;
  bit         mon_en   = 1'b0;

  function automatic logic [7:0] shl(input logic md, input logic [7:0] v);
    return {v[6:0], md ? ~v[7] : v[7]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs against queued expectations every cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy === 1'b1) begin
        if (cyc_q.size() == 0) begin
          check("busy_extra", {31'd0, busy}, 32'd0);
        end else begin
          mon_e = cyc_q.pop_front();
          check("cyc_q",    {24'd0, q},        {24'd0, mon_e.q});
          check("cyc_cnt",  {24'd0, step_cnt}, {24'd0, mon_e.cnt});
          check("cyc_done", {31'd0, done},     {31'd0, mon_e.done});
        end
      end else begin
        check("idle_busy", {31'd0, busy},     32'd0);
        check("idle_done", {31'd0, done},     32'd0);
        check("idle_q",    {24'd0, q},        {24'd0, idle_q});
        check("idle_cnt",  {24'd0, step_cnt}, {24'd0, idle_cnt});
      end
      if (done === 1'b1) begin
        if (fin_q.size() == 0) begin
          check("done_extra", {31'd0, done}, 32'd0);
        end else begin
          mon_f = fin_q.pop_front();
          check("final_q",   {24'd0, q},        {24'd0, mon_f.q});
          check("final_cnt", {24'd0, step_cnt}, {24'd0, mon_f.cnt});
        end
      end
    end
  end

  // One run: h0/hl = RUN edge index where hold starts and its length,
  // noise = toggle start/config while busy, abort_at = step count at which
  // rst is applied (-1 for none), fq/fc = hand-computed final q/step_cnt.
  task automatic run(input logic md, input logic [7:0] sd, input logic [7:0] st,
                     input int h0, input int hl, input bit noise, input int abort_at,
                     input logic [7:0] fq, input logic [7:0] fc);
    int         n_run;
    logic [7:0] mq;
    logic [7:0] mc;
    cyc_q.push_back('{q: m_q, cnt: m_cnt, done: 1'b0});
    mq = sd;
    mc = 8'd0;
    cyc_q.push_back('{q: mq, cnt: mc, done: (st == 8'd0)});
    n_run = 0;
    if (st != 8'd0) begin
      for (int r = 0; mc != st; r++) begin
        if (abort_at >= 0 && mc == abort_at[7:0]) break;
        if (!(r >= h0 && r < h0 + hl)) begin
          mq = shl(md, mq);
          mc = mc + 8'd1;
        end
        cyc_q.push_back('{q: mq, cnt: mc, done: (mc == st)});
        n_run++;
      end
    end
    if (abort_at < 0) fin_q.push_back('{q: fq, cnt: fc});

    mode  = md;
    seed  = sd;
    steps = st;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (noise) begin
      start = 1'b1;
      mode  = ~md;
      seed  = ~sd;
      steps = st + 8'd3;
    end
    @(posedge clk); #1;
    for (int r = 0; r < n_run; r++) begin
      hold = (r >= h0 && r < h0 + hl);
      @(posedge clk); #1;
    end
    hold  = 1'b0;
    start = 1'b0;
    if (abort_at >= 0) begin
      rst      = 1'b1;
      m_q      = 8'd0;
      m_cnt    = 8'd0;
      idle_q   = 8'd0;
      idle_cnt = 8'd0;
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      m_q      = mq;
      m_cnt    = mc;
      idle_q   = mq;
      idle_cnt = mc;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    seed  = 8'd0;
    steps = 8'd0;
    hold  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    run(1'b0, 8'h01, 8'd3,   0, 0, 1'b0, -1, 8'h08, 8'd3);
    run(1'b1, 8'h00, 8'd9,   0, 0, 1'b0, -1, 8'hFE, 8'd9);
    run(1'b0, 8'hA5, 8'd0,   0, 0, 1'b0, -1, 8'hA5, 8'd0);
    run(1'b0, 8'h80, 8'd4,   1, 3, 1'b0, -1, 8'h08, 8'd4);
    run(1'b0, 8'h81, 8'd2,   0, 0, 1'b1, -1, 8'h06, 8'd2);
    run(1'b0, 8'h00, 8'd3,   0, 0, 1'b0, -1, 8'h00, 8'd3);
    run(1'b1, 8'h80, 8'd1,   0, 0, 1'b0, -1, 8'h00, 8'd1);
    run(1'b1, 8'h5A, 8'd16,  0, 0, 1'b0, -1, 8'h5A, 8'd16);
    run(1'b0, 8'h01, 8'd255, 0, 0, 1'b0, -1, 8'h80, 8'd255);
    run(1'b0, 8'h01, 8'd5,   0, 0, 1'b0,  2, 8'h00, 8'd0);
    run(1'b1, 8'h0F, 8'd2,   0, 0, 1'b0, -1, 8'h3F, 8'd2);

    repeat (3) @(posedge clk);
    #1;
    check("leftover_cyc", cyc_q.size(), 32'd0);
    check("leftover_fin", fin_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
